// File: rtl/ce_gen_pkg.sv
// Shared types for the multi-channel clock-enable generator.
// Encodings are fixed because the mode bit arrives raw from the write port.
package ce_gen_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ce_gen_chan.sv
// One clock-enable channel: stored divisor/mode, down-counter and IDLE/RUN state.
// Priority per edge is stop > start > sync > count.
module ce_gen_chan
  import ce_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_arstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_div,
  input  logic             wr_mode,
  input  logic             start,
  input  logic             stop,
  input  logic             sync,
  output logic             ce,
  output logic             busy
);

  logic [WIDTH-1:0] div_reg, div_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  mode_t            mode_reg, mode_next;
  state_t           state_reg, state_next;
  logic             ce_reg, ce_next;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      div_reg   <= '0;
      cnt_reg   <= '0;
      mode_reg  <= MODE_PERIODIC;
      state_reg <= ST_IDLE;
      ce_reg    <= 1'b0;
    end else begin
      div_reg   <= div_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      state_reg <= state_next;
      ce_reg    <= ce_next;
    end
  end

  always_comb begin
    div_next   = div_reg;
    mode_next  = mode_reg;
    cnt_next   = cnt_reg;
    state_next = state_reg;
    ce_next    = 1'b0;

    if (wr_en) begin
      div_next  = wr_div;
      mode_next = mode_t'(wr_mode);
    end

    if (stop) begin
      state_next = ST_IDLE;
    end else if (start) begin
      // div_next carries a same-cycle write so a restart can use it directly
      state_next = ST_RUN;
      cnt_next   = div_next;
    end else if (state_reg == ST_RUN) begin
      if (sync) begin
        cnt_next = div_reg;
      end else if (cnt_reg != '0) begin
        cnt_next = cnt_reg - WIDTH'(1);
      end else begin
        ce_next = 1'b1;
        if (mode_reg == MODE_PERIODIC) cnt_next = div_reg;
        else                           state_next = ST_IDLE;
      end
    end
  end

  assign ce   = ce_reg;
  assign busy = (state_reg == ST_RUN);

endmodule

// File: rtl/ce_gen_multi.sv
// NCH independent clock-enable channels sharing one config write port and a global sync.
// Writes addressed beyond the last channel match no decoder and are dropped.
module ce_gen_multi
  import ce_gen_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_arstn,
  input  logic             i_wr_en,
  input  logic [CHW-1:0]   i_wr_ch,
  input  logic [WIDTH-1:0] i_wr_div,
  input  logic             i_wr_mode,
  input  logic [NCH-1:0]   i_start,
  input  logic [NCH-1:0]   i_stop,
  input  logic             i_sync,
  output logic [NCH-1:0]   o_ce,
  output logic [NCH-1:0]   o_busy
);

  logic [NCH-1:0] wr_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign wr_hit[gi] = i_wr_en && (i_wr_ch == CHW'(gi));

      ce_gen_chan #(
        .WIDTH (WIDTH)
      ) u_chan (
        .i_clk   (i_clk),
        .i_arstn (i_arstn),
        .wr_en   (wr_hit[gi]),
        .wr_div  (i_wr_div),
        .wr_mode (i_wr_mode),
        .start   (i_start[gi]),
        .stop    (i_stop[gi]),
        .sync    (i_sync),
        .ce      (o_ce[gi]),
        .busy    (o_busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ce_gen_multi.sv
// Directed bench for ce_gen_multi: a 4-channel instance for the main scenarios
// and a 3-channel instance for the out-of-range write address.
module tb_ce_gen_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [31:0] wr_div;
  logic        wr_mode;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic        sync;
  logic [3:0]  ce;
  logic [3:0]  busy;

  logic        wr_en3;
  logic [1:0]  wr_ch3;
  logic [31:0] wr_div3;
  logic        wr_mode3;
  logic [2:0]  start3;
  logic [2:0]  stop3;
  logic        sync3;
  logic [2:0]  ce3;
  logic [2:0]  busy3;

  int total = 0;
  int bad   = 0;

  ce_gen_multi #(.WIDTH(32), .NCH(4)) u_dut (
    .i_clk     (clk),
    .i_arstn   (arstn),
    .i_wr_en   (wr_en),
    .i_wr_ch   (wr_ch),
    .i_wr_div  (wr_div),
    .i_wr_mode (wr_mode),
    .i_start   (start),
    .i_stop    (stop),
    .i_sync    (sync),
    .o_ce      (ce),
    .o_busy    (busy)
  );

  ce_gen_multi #(.WIDTH(32), .NCH(3)) u_dut3 (
    .i_clk     (clk),
    .i_arstn   (arstn),
    .i_wr_en   (wr_en3),
    .i_wr_ch   (wr_ch3),
    .i_wr_div  (wr_div3),
    .i_wr_mode (wr_mode3),
    .i_start   (start3),
    .i_stop    (stop3),
    .i_sync    (sync3),
    .o_ce      (ce3),
    .o_busy    (busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int ch, input int dv, input logic md);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_div  = 32'(dv);
    wr_mode = md;
    $display("wr ch=%0d div=%0d mode=%0d", ch, dv, md);
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    start = m;
    $display("start mask=%b", m);
    step();
    start = '0;
  endtask

  int npulse;

  initial begin
    arstn = 1'b0;
    wr_en = 0; wr_ch = 0; wr_div = 0; wr_mode = 0; start = 0; stop = 0; sync = 0;
    wr_en3 = 0; wr_ch3 = 0; wr_div3 = 0; wr_mode3 = 0; start3 = 0; stop3 = 0; sync3 = 0;
    #2;
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ce3", 32'(ce3), 32'h0);
    chk("rst_busy3", 32'(busy3), 32'h0);
    step(); step();
    arstn = 1'b1;
    step();

    // ch0 with reset divisor 0: continuous enable
    pulse_start(4'b0001);
    chk("t1_busy_start", 32'(busy), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t1_ce", 32'(ce), 32'h1);
      chk("t1_busy", 32'(busy), 32'h1);
    end
    stop = 4'b0001; step(); stop = '0;
    chk("t1_stop_ce", 32'(ce), 32'h0);
    chk("t1_stop_busy", 32'(busy), 32'h0);

    // ch1 periodic div=5: pulse every 6 cycles
    wr(1, 5, 1'b0);
    pulse_start(4'b0010);
    npulse = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("t2_ce1", 32'(ce[1]), 32'(k % 6 == 0));
      npulse += int'(ce[1]);
    end
    chk("t2_npulse", 32'(npulse), 32'd5);

    // divisor rewritten mid-period: current pulse at 36, then every 3
    for (int k = 31; k <= 45; k++) begin
      step();
      chk("t2b_ce1", 32'(ce[1]), 32'(k == 36 || (k > 36 && (k - 36) % 3 == 0)));
      if (k == 31) begin
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 32'd2; wr_mode = 1'b0;
        $display("wr ch=1 div=2 mode=0 (mid-period)");
      end
      if (k == 32) wr_en = 1'b0;
    end
    stop = 4'b0010; step(); stop = '0;
    chk("t2b_stop_ce", 32'(ce), 32'h0);
    chk("t2b_stop_busy", 32'(busy), 32'h0);

    // ch2 one-shot div=3
    wr(2, 3, 1'b1);
    pulse_start(4'b0100);
    chk("t3_busy_start", 32'(busy[2]), 32'h1);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("t3_ce2", 32'(ce[2]), 32'(k == 4));
      chk("t3_busy2", 32'(busy[2]), 32'(k < 4));
    end

    // sync realigns ch0 (div 3) and ch1 (div 5)
    wr(0, 3, 1'b0);
    wr(1, 5, 1'b0);
    pulse_start(4'b0001);
    step(); step();
    pulse_start(4'b0010);
    step(); step(); step();
    sync = 1'b1;
    $display("sync");
    step();
    sync = 1'b0;
    chk("t4_ce_at_sync", 32'(ce), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t4_ce0", 32'(ce[0]), 32'(k % 4 == 0));
      chk("t4_ce1", 32'(ce[1]), 32'(k % 6 == 0));
      chk("t4_ce3", 32'(ce[3]), 32'h0);
      chk("t4_busy3", 32'(busy[3]), 32'h0);
    end
    chk("t4_busy", 32'(busy), 32'h3);
    stop = 4'b1111; step(); stop = '0;
    chk("t4_stop_busy", 32'(busy), 32'h0);

    // start and stop together: stop wins
    start = 4'b0010; stop = 4'b0010;
    $display("start+stop ch1");
    step();
    start = '0; stop = '0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_ce", 32'(ce), 32'h0);
    end

    // NCH=3: write to channel 3 must hit nothing
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div3 = 32'd7; wr_mode3 = 1'b1;
    $display("wr3 ch=3 div=7 mode=1");
    step();
    wr_en3 = 1'b0;
    start3 = 3'b111;
    $display("start3 mask=111");
    step();
    start3 = '0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t6_ce3", 32'(ce3), 32'h7);
      chk("t6_busy3", 32'(busy3), 32'h7);
    end

    // asynchronous reset in the middle of a cycle
    wr(0, 0, 1'b0);
    pulse_start(4'b0011);
    step(); step();
    chk("t7_pre_ce", 32'(ce), 32'h1);
    chk("t7_pre_busy", 32'(busy), 32'h3);
    #2;
    arstn = 1'b0;
    $display("async reset asserted");
    #1;
    chk("t7_ce", 32'(ce), 32'h0);
    chk("t7_busy", 32'(busy), 32'h0);
    chk("t7_ce3", 32'(ce3), 32'h0);
    chk("t7_busy3", 32'(busy3), 32'h0);
    step();
    arstn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t7_post_busy", 32'(busy), 32'h0);
      chk("t7_post_ce", 32'(ce), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
